// File: rtl/fir_mac_sequencer.sv
// Tap/channel sequencer for the multichannel FIR MAC bank: steps coefficients, frames sums, rotates channels.
// Optional macro SYNC_SRDYI_EN adds a 2-flop synchronizer on srdyi ahead of the edge detector.
module fir_mac_sequencer #(
    parameter int NUM_TAPS = 12,
    parameter int NUM_CH   = 32,
    parameter int MAC_LAT  = 2,
    localparam int TAP_W   = $clog2(NUM_TAPS),
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic             srdyi,
    input  logic             clr_ovr,
    output logic             srdyo,
    output logic             sum_en,
    output logic             sum_rst,
    output logic [TAP_W-1:0] coeff_sel,
    output logic [CH_W-1:0]  ch_sel,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic [2:0] {IDLE, ACC, DRAIN, DONE, CLEAR} state_t;

    localparam logic [TAP_W-1:0] LAST_TAP  = TAP_W'(NUM_TAPS - 1);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [3:0]       DRAIN_END = (MAC_LAT == 0) ? 4'd0 : 4'(MAC_LAT - 1);

    state_t     state;
    logic [3:0] drain_cnt;
    logic       srdyi_det;
    logic       srdyi_q;
    logic       tap_stb;
    logic       last_pending;
    logic       accept;
    logic       drop;

`ifdef SYNC_SRDYI_EN
    logic sync_1;
    logic sync_2;

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= srdyi;
            sync_2 <= sync_1;
        end
    end

    assign srdyi_det = sync_2;
`else
    assign srdyi_det = srdyi;
`endif

    // The final tap's sum_en cycle still sits in ACC; no new tap may start a frame then.
    assign tap_stb      = srdyi_det & ~srdyi_q;
    assign last_pending = sum_en && (coeff_sel == LAST_TAP);
    assign accept       = tap_stb && ((state == IDLE) || ((state == ACC) && !last_pending));
    assign drop         = tap_stb && !accept;

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state     <= IDLE;
            drain_cnt <= 4'd0;
            srdyi_q   <= 1'b0;
            srdyo     <= 1'b0;
            sum_en    <= 1'b0;
            sum_rst   <= 1'b0;
            coeff_sel <= '0;
            ch_sel    <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            srdyi_q <= srdyi_det;
            sum_en  <= accept;
            srdyo   <= 1'b0;
            sum_rst <= 1'b0;

            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ACC;
                        busy  <= 1'b1;
                    end
                end
                ACC: begin
                    if (last_pending) begin
                        if (MAC_LAT == 0) begin
                            state <= DONE;
                            srdyo <= 1'b1;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= 4'd0;
                        end
                    end else if (sum_en) begin
                        coeff_sel <= coeff_sel + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_END) begin
                        state <= DONE;
                        srdyo <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                DONE: begin
                    state   <= CLEAR;
                    sum_rst <= 1'b1;
                end
                CLEAR: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    coeff_sel <= '0;
                    ch_sel    <= (ch_sel == LAST_CH) ? '0 : ch_sel + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: frame-timing reference model plus directed and random srdyi traffic.
module tb_fir_mac_sequencer;

    localparam int NUM_TAPS = 12;
    localparam int NUM_CH   = 4;
    localparam int MAC_LAT  = 2;
    localparam int TAP_W    = $clog2(NUM_TAPS);
    localparam int CH_W     = 2;
`ifdef SYNC_SRDYI_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             GlobalReset = 1'b1;
    logic             srdyi = 1'b0;
    logic             clr_ovr = 1'b0;
    logic             srdyo;
    logic             sum_en;
    logic             sum_rst;
    logic [TAP_W-1:0] coeff_sel;
    logic [CH_W-1:0]  ch_sel;
    logic             busy;
    logic             overrun;

    fir_mac_sequencer #(.NUM_TAPS(NUM_TAPS), .NUM_CH(NUM_CH), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .GlobalReset(GlobalReset), .srdyi(srdyi), .clr_ovr(clr_ovr),
        .srdyo(srdyo), .sum_en(sum_en), .sum_rst(sum_rst), .coeff_sel(coeff_sel),
        .ch_sel(ch_sel), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a frame is a count of accepted taps; once the last one lands at
    // cycle fe, srdyo/sum_rst/idle follow at fe+MAC_LAT+1/+2/+3 and strobes before that drop.
    int hist[4];
    int m_taps, m_ch, m_fe, m_ovr, n;
    int e_sum_en = 0, e_srdyo = 0, e_sum_rst = 0, e_coeff = 0, e_ch = 0, e_busy = 0, e_ovr = 0;

    always @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            for (int i = 0; i < 4; i++) hist[i] = 0;
            m_taps = 0; m_ch = 0; m_fe = -1; m_ovr = 0; n = 0;
            e_sum_en = 0; e_srdyo = 0; e_sum_rst = 0; e_coeff = 0; e_ch = 0; e_busy = 0; e_ovr = 0;
        end else begin
            int stb, acc, drp;
            n++;
            hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = int'(srdyi);
            if (LAT == 1) stb = hist[0] & ~hist[1] & 1;
            else          stb = hist[2] & ~hist[3] & 1;
            acc = (stb != 0 && m_fe < 0) ? 1 : 0;
            drp = (stb != 0 && m_fe >= 0) ? 1 : 0;
            e_sum_en = acc;
            if (acc != 0) begin
                e_coeff = m_taps;
                m_taps++;
                if (m_taps == NUM_TAPS) m_fe = n;
            end
            if (drp != 0) m_ovr = 1;
            else if (clr_ovr) m_ovr = 0;
            if (m_fe >= 0 && n == m_fe + MAC_LAT + 3) begin
                m_taps = 0;
                m_ch   = (m_ch + 1) % NUM_CH;
                m_fe   = -1;
            end
            e_srdyo   = (m_fe >= 0 && n == m_fe + MAC_LAT + 1) ? 1 : 0;
            e_sum_rst = (m_fe >= 0 && n == m_fe + MAC_LAT + 2) ? 1 : 0;
            if (acc == 0) e_coeff = (m_fe >= 0) ? NUM_TAPS - 1 : m_taps;
            e_busy = (m_taps > 0 || m_fe >= 0) ? 1 : 0;
            e_ch   = m_ch;
            e_ovr  = m_ovr;
        end
    end

    always @(negedge clk) begin
        if (!GlobalReset) begin
            checkOutput("sum_en",    int'(sum_en),    e_sum_en);
            checkOutput("srdyo",     int'(srdyo),     e_srdyo);
            checkOutput("sum_rst",   int'(sum_rst),   e_sum_rst);
            checkOutput("coeff_sel", int'(coeff_sel), e_coeff);
            checkOutput("ch_sel",    int'(ch_sel),    e_ch);
            checkOutput("busy",      int'(busy),      e_busy);
            checkOutput("overrun",   int'(overrun),   e_ovr);
        end
    end

    // Event log used by the hand-computed literal checks.
    int en_cnt, srdyo_cnt, rst_cnt, last_en_cyc, last_srdyo_cyc, last_rst_cyc, last_en_coeff;
    int coeff_log[NUM_TAPS];
    int ch_log[8];

    always @(negedge clk) begin
        if (GlobalReset) begin
            en_cnt = 0; srdyo_cnt = 0; rst_cnt = 0;
        end else begin
            if (sum_en) begin
                coeff_log[en_cnt % NUM_TAPS] = int'(coeff_sel);
                last_en_coeff = int'(coeff_sel);
                last_en_cyc = cyc;
                en_cnt++;
            end
            if (srdyo) begin
                ch_log[srdyo_cnt % 8] = int'(ch_sel);
                last_srdyo_cyc = cyc;
                srdyo_cnt++;
            end
            if (sum_rst) begin
                last_rst_cyc = cyc;
                rst_cnt++;
            end
        end
    end

    int drive_cyc;

    task automatic waitCycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic applyStimulus(input int high, input int low);
        @(negedge clk); #1;
        srdyi = 1'b1;
        drive_cyc = cyc;
        repeat (high) @(negedge clk);
        #1 srdyi = 1'b0;
        repeat (low - 1) @(negedge clk);
    endtask

    task automatic resetDut();
        @(negedge clk); #1;
        GlobalReset = 1'b1;
        srdyi = 1'b0;
        clr_ovr = 1'b0;
        waitCycles(2);
        #1 GlobalReset = 1'b0;
    endtask

    task automatic runFrame();
        repeat (NUM_TAPS) applyStimulus(2, 4);
        waitCycles(4);
    endtask

    initial begin
        int hi, lo;
        $display("[TB] start, acceptance latency %0d", LAT);
        resetDut();
        waitCycles(1);
        checkOutput("reset_coeff", int'(coeff_sel), 0);
        checkOutput("reset_busy", int'(busy), 0);

        // One full frame from reset
        runFrame();
        checkOutput("t1_en_count", en_cnt, 12);
        for (int i = 0; i < NUM_TAPS; i++) checkOutput("t1_coeff_seq", coeff_log[i], i);
        checkOutput("t1_srdyo_delay", last_srdyo_cyc - last_en_cyc, 3);
        checkOutput("t1_rst_delay", last_rst_cyc - last_srdyo_cyc, 1);
        checkOutput("t1_ch_after", int'(ch_sel), 1);
        checkOutput("t1_coeff_after", int'(coeff_sel), 0);

        // Four frames rotate through all channels
        resetDut();
        repeat (4) runFrame();
        checkOutput("t2_srdyo_count", srdyo_cnt, 4);
        checkOutput("t2_rst_count", rst_cnt, 4);
        for (int i = 0; i < 4; i++) checkOutput("t2_ch_seq", ch_log[i], i);
        checkOutput("t2_ch_wrap", int'(ch_sel), 0);
        checkOutput("t2_overrun", int'(overrun), 0);

        // Held level gives a single strobe
        resetDut();
        applyStimulus(20, 4);
        checkOutput("t3_en_count", en_cnt, 1);
        checkOutput("t3_coeff", last_en_coeff, 0);
        checkOutput("t3_latency", last_en_cyc - drive_cyc, LAT);

        // Strobe dropped during DRAIN, then clear, then drop coincident with clear
        resetDut();
        repeat (NUM_TAPS - 1) applyStimulus(2, 4);
        applyStimulus(1, 1);
        applyStimulus(1, 1);
        waitCycles(10);
        checkOutput("t4_en_count", en_cnt, 12);
        checkOutput("t4_overrun_set", int'(overrun), 1);
        checkOutput("t4_frame_done", srdyo_cnt, 1);
        @(negedge clk); #1 clr_ovr = 1'b1;
        @(negedge clk); #1 clr_ovr = 1'b0;
        checkOutput("t4_overrun_clr", int'(overrun), 0);
        repeat (NUM_TAPS - 1) applyStimulus(2, 4);
        applyStimulus(1, 1);
        for (int i = 0; i <= LAT; i++) begin
            @(negedge clk); #1;
            srdyi   = (i == 0);
            clr_ovr = (i == LAT - 1);
        end
        waitCycles(2);
        checkOutput("t4_set_wins", int'(overrun), 1);
        waitCycles(8);

        // Asynchronous reset mid-frame
        resetDut();
        runFrame();
        repeat (5) applyStimulus(2, 4);
        waitCycles(1);
        checkOutput("t5_coeff_mid", int'(coeff_sel), 5);
        checkOutput("t5_ch_mid", int'(ch_sel), 1);
        @(negedge clk); #1 GlobalReset = 1'b1;
        #1;
        checkOutput("t5_async_out", {25'd0, sum_en, srdyo, sum_rst, busy, overrun, ch_sel} == 0 ? 0 : 1, 0);
        checkOutput("t5_async_coeff", int'(coeff_sel), 0);
        waitCycles(2);
        #1 GlobalReset = 1'b0;
        runFrame();
        checkOutput("t5_one_frame", srdyo_cnt, 1);
        checkOutput("t5_frame_ch", ch_log[0], 0);

        // Random traffic with occasional overrun clears
        resetDut();
        repeat (400) begin
            hi = $urandom_range(1, 3);
            lo = $urandom_range(1, 6);
            for (int i = 0; i < hi + lo; i++) begin
                @(negedge clk); #1;
                srdyi   = (i < hi);
                clr_ovr = ($urandom_range(0, 15) == 0);
            end
        end
        srdyi = 1'b0;
        clr_ovr = 1'b0;
        waitCycles(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Parametrised tap/channel sequencer for the multichannel FIR datapath.
- Counts input sample strobes (srdyi) and steps the coefficient select through NUM_TAPS taps.
- Drives the accumulator enable/reset and pulses srdyo when a channel's sum is valid.
- Rotates across NUM_CH channels and flags strobes that arrive while the block is busy.
- Single-clock, fully synchronous; sits between the sample front-end and the MAC/accumulator bank.

Parameters:
NUM_TAPS, 12, taps per output sample (>=2); TAP_W = clog2(NUM_TAPS)
NUM_CH, 32, channels served round-robin (>=1); CH_W = max(1, clog2(NUM_CH))
MAC_LAT, 2, MAC pipeline depth in cycles between last sum_en and valid sum (0..15)

Ports:
clk  in  1  clock, all logic on rising edge
GlobalReset  in  1  asynchronous, active-high reset
srdyi  in  1  sample-ready level from front-end; each rising edge = one tap strobe
clr_ovr  in  1  synchronous clear of overrun flag
srdyo  out  1  one-cycle pulse: accumulated sum for ch_sel valid
sum_en  out  1  one-cycle accumulate enable per accepted tap
sum_rst  out  1  one-cycle accumulator clear after srdyo
coeff_sel  out  TAP_W  tap index, valid coincident with sum_en
ch_sel  out  CH_W  current channel index
busy  out  1  high whenever state != IDLE
overrun  out  1  sticky: strobe dropped while not accepting

Behaviour:
- Reset (async assert, sync release): state=IDLE; srdyo=0, sum_en=0, sum_rst=0, coeff_sel=0, ch_sel=0, busy=0, overrun=0; srdyi edge-detect flop=0.
- Reset mid-frame aborts immediately. No srdyo/sum_rst is emitted for the partial frame.
- tap_stb = srdyi high at a clk edge while srdyi was low at the previous edge. A level held high gives one strobe only.
- States: IDLE, ACC, DRAIN, DONE, CLEAR. All outputs are registered.
- IDLE/ACC, tap_stb accepted:
  - sum_en=1 next cycle, with coeff_sel = current tap index k.
  - coeff_sel becomes k+1 in the following cycle.
  - IDLE->ACC on the first tap.
- Acceptance latency: srdyi first sampled high at edge e -> sum_en high in the cycle after edge e.
- Tap k = NUM_TAPS-1 accepted: sum_en pulses as usual. Next state is DRAIN, or DONE directly if MAC_LAT=0. coeff_sel holds NUM_TAPS-1; it never exceeds NUM_TAPS-1.
- DRAIN: counts MAC_LAT cycles, then goes to DONE.
- DONE: srdyo=1 for exactly 1 cycle, then goes to CLEAR.
- CLEAR: sum_rst=1 for exactly 1 cycle; coeff_sel<=0; ch_sel<=ch_sel+1, wrapping to 0 after NUM_CH-1; then goes to IDLE.
- Frame timing, last sum_en in cycle t:
  - srdyo in cycle t+MAC_LAT+1
  - sum_rst in cycle t+MAC_LAT+2
  - next tap accepted from the edge ending cycle t+MAC_LAT+3 (IDLE)
- srdyo, sum_rst and sum_en are mutually exclusive in every cycle.
- tap_stb in DRAIN/DONE/CLEAR: dropped. No sum_en, no counter change; overrun<=1 next cycle.
- overrun is cleared by clr_ovr when no new drop occurs in the same cycle. A simultaneous drop and clr_ovr leaves overrun=1 (set wins).
- NUM_CH=1: ch_sel stays 0.

Optional Feature:
SYNC_SRDYI_EN:
- Defined: srdyi passes through a 2-flop synchronizer (reset to 0) before edge detection. Acceptance latency becomes 3 cycles from first sampling; all other relative timing is unchanged.
- Undefined: srdyi is treated as synchronous to clk and edge-detected directly (1-cycle latency).

Test Plan:
1. Reset, then 12 srdyi pulses (2 high/4 low) with NUM_TAPS=12, NUM_CH=4, MAC_LAT=2 -> 12 sum_en pulses with coeff_sel 0..11. srdyo 3 cycles after the 12th sum_en, sum_rst the next cycle, then ch_sel=1 and coeff_sel=0.
2. Run 4 full frames -> ch_sel sequence 0,1,2,3,0. Exactly 4 srdyo and 4 sum_rst pulses; overrun stays 0.
3. srdyi held high for 20 cycles -> exactly 1 sum_en with coeff_sel=0.
4. srdyi pulse in the cycle after the 12th sum_en (DRAIN) -> no sum_en, overrun=1, frame completes normally. clr_ovr pulse -> overrun=0. Drop coincident with clr_ovr -> overrun stays 1.
5. GlobalReset asserted after tap 5 -> all outputs 0 asynchronously, no srdyo. Next frame starts at coeff_sel=0, ch_sel=0.
6. MAC_LAT=0 and SYNC_SRDYI_EN defined -> sum_en 3 cycles after srdyi first sampled high; srdyo in the cycle immediately after the 12th sum_en.
